// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the row
// pattern on scan ticks, and emits one encoded key per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       trig,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       digit_stb,
  output logic       key_held
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_meta_q, rs_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              digit_stb_q, digit_stb_d;
  logic              key_held_q, key_held_d;
  logic              tick;
  logic [3:0]        key_new;

  // Lowest-numbered low row wins when several rows are pulled down.
  function automatic logic [3:0] key_map(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] v;
    if (!pat[0])      r = 2'd0;
    else if (!pat[1]) r = 2'd1;
    else if (!pat[2]) r = 2'd2;
    else              r = 2'd3;
    unique case ({r, c})
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h3;
      4'h3: v = 4'hA;
      4'h4: v = 4'h4;
      4'h5: v = 4'h5;
      4'h6: v = 4'h6;
      4'h7: v = 4'hB;
      4'h8: v = 4'h7;
      4'h9: v = 4'h8;
      4'hA: v = 4'h9;
      4'hB: v = 4'hC;
      4'hC: v = 4'hE;
      4'hD: v = 4'h0;
      4'hE: v = 4'hF;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  assign tick    = (div_q == DivLast);
  assign key_new = key_map(pat_q, idx_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    key_d       = key_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    digit_stb_d = 1'b0;
    // The column only ever changes on a tick, where the divider wraps anyway.
    div_d       = tick ? '0 : div_q + DivW'(1);
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (rs_q == 4'hF) begin
            idx_d = idx_q + 2'd1;
          end else begin
            pat_d   = rs_q;
            cnt_d   = CntW'(1);
            state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (rs_q == pat_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q + CntW'(1) == DebLast) begin
              state_d     = StPressed;
              key_d       = key_new;
              key_valid_d = 1'b1;
              digit_stb_d = (key_new <= 4'd9);
              key_held_d  = 1'b1;
            end
          end else begin
            state_d = StScan;
            idx_d   = idx_q + 2'd1;
          end
        end
        StPressed: begin
          if (rs_q == 4'hF) begin
            state_d = StRelease;
            cnt_d   = CntW'(1);
          end
        end
        StRelease: begin
          if (rs_q == 4'hF) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q + CntW'(1) == DebLast) begin
              key_held_d = 1'b0;
              state_d    = StScan;
              idx_d      = idx_q + 2'd1;
            end
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StScan;
      endcase
    end
    col_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge trig or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= 4'hF;
      rs_q        <= 4'hF;
      state_q     <= StScan;
      div_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pat_q       <= 4'hF;
      col_q       <= 4'b1110;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      digit_stb_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row;
      rs_q        <= row_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      col_q       <= col_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      digit_stb_q <= digit_stb_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign digit_stb = digit_stb_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad matrix model (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scanner;

  logic            trig;
  logic            reset;
  logic [3:0]      row;
  logic [3:0]      col;
  logic [3:0]      key;
  logic            key_valid;
  logic            digit_stb;
  logic            key_held;
  logic [3:0][3:0] prs;  // prs[r][c]: key at row r, column c is physically closed

  int total;
  int bad;
  int kv_cnt;
  int ds_cnt;
  int consec_cnt;
  logic kv_prev;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) u_dut (
    .trig      (trig),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .digit_stb (digit_stb),
    .key_held  (key_held)
  );

  initial begin
    trig = 1'b0;
    forever #5 trig = ~trig;
  end

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (prs[r][c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  initial begin
    kv_cnt     = 0;
    ds_cnt     = 0;
    consec_cnt = 0;
    kv_prev    = 1'b0;
  end

  always @(negedge trig) begin
    if (key_valid) kv_cnt++;
    if (digit_stb) ds_cnt++;
    if ((key_valid || digit_stb) && kv_prev) consec_cnt++;
    kv_prev = key_valid || digit_stb;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] tgt, input int budget);
    int n;
    n = 0;
    while (col !== tgt && n < budget) begin
      @(negedge trig);
      n++;
    end
    check_eq("wait_col", col, tgt);
  endtask

  task automatic wait_kv(input int budget, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      @(negedge trig);
      n++;
    end
    check_eq("kv_seen", key_valid, 1);
  endtask

  task automatic wait_release(input int budget, output int n);
    n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      @(negedge trig);
      n++;
    end
    check_eq("held_drop", key_held, 0);
  endtask

  int n;
  int base;
  int dbase;
  logic [3:0] exp_col;

  initial begin
    total = 0;
    bad   = 0;
    prs   = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge trig);
    check_eq("rst_col", col, 4'hE);
    check_eq("rst_key", key, 0);
    check_eq("rst_kv", key_valid, 0);
    check_eq("rst_ds", digit_stb, 0);
    check_eq("rst_held", key_held, 0);
    reset = 1'b1;

    // Idle scan: one column per 4 cycles, wrapping.
    for (int k = 0; k < 64; k++) begin
      exp_col = 4'hF ^ (4'h1 << ((k / 4) % 4));
      check_eq("scan_col", col, exp_col);
      check_eq("scan_quiet", {key_valid, digit_stb, key_held}, 0);
      @(negedge trig);
    end

    // Key '6' at row 1, col 2.
    wait_col(4'b1011, 64);
    prs[1][2] = 1'b1;
    wait_kv(40, n);
    check_eq("k6_lat", n, 12);
    check_eq("k6_key", key, 4'h6);
    check_eq("k6_ds", digit_stb, 1);
    check_eq("k6_held", key_held, 1);
    check_eq("k6_col", col, 4'b1011);
    @(negedge trig);
    check_eq("k6_kv_pulse", key_valid, 0);
    check_eq("k6_ds_pulse", digit_stb, 0);
    check_eq("k6_held2", key_held, 1);
    prs = '0;
    wait_release(40, n);
    check_eq("k6_rel_lat", n, 11);
    check_eq("k6_rel_col", col, 4'b0111);

    // '#' at row 3, col 2: operator key, no digit strobe.
    wait_col(4'b1011, 64);
    dbase = ds_cnt;
    base  = kv_cnt;
    prs[3][2] = 1'b1;
    wait_kv(40, n);
    check_eq("hash_key", key, 4'hF);
    check_eq("hash_ds", digit_stb, 0);
    @(negedge trig);
    prs = '0;
    wait_release(40, n);
    check_eq("hash_kv_cnt", kv_cnt - base, 1);
    check_eq("hash_ds_cnt", ds_cnt - dbase, 0);

    // Press bounce on '5' (row 1, col 1): opens before the second stable tick.
    wait_col(4'b1101, 64);
    base = kv_cnt;
    prs[1][1] = 1'b1;
    repeat (5) @(negedge trig);
    prs = '0;
    repeat (3) @(negedge trig);
    check_eq("bnc_abort_col", col, 4'b1011);
    check_eq("bnc_abort_held", key_held, 0);
    check_eq("bnc_no_kv", kv_cnt - base, 0);
    prs[1][1] = 1'b1;
    wait_kv(60, n);
    check_eq("bnc_lat", n, 24);
    check_eq("bnc_key", key, 4'h5);
    // Release bounce: one re-close tick must return to pressed without a new key.
    @(negedge trig);
    prs = '0;
    repeat (4) @(negedge trig);
    prs[1][1] = 1'b1;
    repeat (4) @(negedge trig);
    prs = '0;
    wait_release(40, n);
    check_eq("bnc_rel_lat", n, 11);
    check_eq("bnc_kv_cnt", kv_cnt - base, 1);
    check_eq("bnc_rel_col", col, 4'b1011);

    // Rows 0 and 2 in col 1: lowest row wins, long hold gives one key.
    wait_col(4'b1101, 64);
    base = kv_cnt;
    prs[0][1] = 1'b1;
    prs[2][1] = 1'b1;
    wait_kv(40, n);
    check_eq("multi_key", key, 4'h2);
    check_eq("multi_ds", digit_stb, 1);
    repeat (200) @(negedge trig);
    check_eq("multi_kv_cnt", kv_cnt - base, 1);
    check_eq("multi_held", key_held, 1);
    check_eq("multi_col", col, 4'b1101);
    prs = '0;
    wait_release(40, n);

    // Reset in debounce one tick before acceptance, then redetect after reset.
    wait_col(4'b0111, 64);
    wait_col(4'b1011, 64);
    base = kv_cnt;
    prs[1][2] = 1'b1;
    repeat (9) @(negedge trig);
    #1 reset = 1'b0;
    #1;
    check_eq("mr_col", col, 4'hE);
    check_eq("mr_key", key, 0);
    check_eq("mr_kv", key_valid, 0);
    check_eq("mr_ds", digit_stb, 0);
    check_eq("mr_held", key_held, 0);
    check_eq("mr_no_kv", kv_cnt - base, 0);
    repeat (2) @(negedge trig);
    reset = 1'b1;
    wait_kv(60, n);
    check_eq("mr_lat", n, 20);
    check_eq("mr_key6", key, 4'h6);
    @(negedge trig);
    check_eq("mr_kv_cnt", kv_cnt - base, 1);
    prs = '0;
    wait_release(40, n);
    check_eq("consec", consec_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the calculator's 4x4 matrix keypad, debounces presses, and encodes each accepted press as a 4-bit key value.
- Sits directly upstream of the digit-entry shift register.
- key feeds the shift register's 4-bit digit input; digit_stb drives its trig input.
- Operator keys (A-D, *, #) go to the calculator control logic via key/key_valid.

Parameters:
SCAN_DIV, 1000, clock cycles spent on each column per scan step (minimum 4).
DEBOUNCE, 8, consecutive scan ticks a row pattern must stay stable to accept a press or a release (minimum 2).

Ports:
trig  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
row  input  4  keypad rows; asynchronous, pulled up, active-low.
col  output  4  keypad column drive, active-low, exactly one bit low at any time.
key  output  4  encoded value of the last accepted key; holds until the next accepted key.
key_valid  output  1  one-cycle pulse when a new key is accepted.
digit_stb  output  1  one-cycle pulse, key_valid AND key is 0-9; drives the shift register trig.
key_held  output  1  high while an accepted key is still physically pressed.

Behaviour:
- Reset (asynchronous, reset=0):
  - col=4'b1110 (column 0 driven), key=0, key_valid=0, digit_stb=0, key_held=0.
  - State SCAN, column index 0, divider 0, debounce counter 0.
  - Row synchronizer flops set to 4'hF.
  - Reset asserted mid-press or mid-debounce aborts immediately; no pulse is emitted on release of reset.
- Row input: 2-flop synchronizer. All logic uses the synchronized value rs.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick = (divider == SCAN_DIV-1).
  - All state decisions below occur only on tick edges.
  - The divider restarts at 0 whenever col changes.
- Row index: lowest-numbered low bit of rs. Multiple low rows means the lowest index wins.
- Key map (row, col -> value), rows 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D (E = '*', F = '#')
- States:
  - SCAN: col = ~(1 << idx).
    - rs == 4'hF: idx advances, wrapping 3 -> 0.
    - Otherwise: latch pattern p = rs, debounce counter = 1, go to DEBOUNCE. col is held.
  - DEBOUNCE:
    - rs == p: counter increments.
    - rs != p (including 4'hF): return to SCAN and advance idx. No output change.
    - Counter reaches DEBOUNCE: go to PRESSED and register key = map(row index of p, idx). key_valid=1 for exactly the next cycle; digit_stb likewise when the value is <= 9. key_held=1.
  - PRESSED: col held.
    - rs == 4'hF: go to RELEASE with counter = 1.
    - Any other rs (e.g. a second key in the same column): ignored.
  - RELEASE:
    - rs == 4'hF: counter increments.
    - rs != 4'hF: return to PRESSED. This is bounce, so no new key_valid.
    - Counter reaches DEBOUNCE: key_held=0, go to SCAN, advance idx.
- No auto-repeat: a held key produces exactly one key_valid.
- Rollover:
  - A second key pressed in another column while the first is held is never seen, because that column is not driven.
  - The second key is detected normally after the first is released.
- Latency: key_valid goes high on the cycle after the edge where the DEBOUNCE-th stable tick is counted. That is DEBOUNCE-1 ticks ((DEBOUNCE-1)*SCAN_DIV cycles) after the detecting tick.
- key_valid and digit_stb are never high on consecutive cycles.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE=3, no keys pressed for 64 cycles -> col cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid, digit_stb and key_held stay 0.
2. Hold row 1 low while col 2 is driven (key '6'), stable -> col held at 1011; after 2 further ticks key=4'h6, key_valid and digit_stb each high for one cycle, key_held=1. Release -> key_held drops 3 ticks later and scanning resumes at col 3.
3. Press '#' (row 3, col 2) -> key=4'hF, key_valid pulses once, digit_stb stays 0.
4. Row pattern toggles each tick for the first 2 ticks after detection (bounce) -> no key_valid until 3 consecutive stable ticks. During release, one re-close tick -> back to PRESSED, no second key_valid.
5. Rows 0 and 2 low together in col 1 -> key=4'h2 (lowest row wins). Key held for 200 cycles -> exactly one key_valid.
6. Assert reset in DEBOUNCE one tick before acceptance -> outputs immediately at reset values, col=1110. Deassert with the key still held -> a fresh detect/debounce follows when col 2 comes round, giving one key_valid.
